// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the N-way write-through cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        RD_MISS = 2'd2,
        WR_THRU = 2'd3
    } cache_state_e;

    function automatic int tag_w(input int addr_w, input int set_bits);
        return addr_w - set_bits;
    endfunction

    function automatic int way_idx_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int nsets(input int set_bits);
        return 1 << set_bits;
    endfunction

endpackage

// File: rtl/cache_plru_sel.sv
// Combinational bit-PLRU helper: picks a victim way and computes the MRU vector
// that results from touching a given way.
module cache_plru_sel #(
    parameter int WAYS      = 4,
    parameter int WAY_IDX_W = 2
) (
    input  logic [WAYS-1:0]      valid,
    input  logic [WAYS-1:0]      mru,
    input  logic [WAY_IDX_W-1:0] access_way,
    output logic [WAY_IDX_W-1:0] victim,
    output logic [WAYS-1:0]      mru_next
);

    logic            found;
    logic [WAYS-1:0] touched;

    // Invalid ways take priority over the lowest not-recently-used way.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !valid[i]) begin
                victim = WAY_IDX_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !mru[i]) begin
                victim = WAY_IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

    // Never let every MRU bit become set: restart the epoch at the accessed way.
    always_comb begin
        touched  = WAYS'(1) << access_way;
        mru_next = mru | touched;
        if (&mru_next) begin
            mru_next = touched;
        end
    end

endmodule

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative, write-through, no-write-allocate cache controller with
// valid-clear init sequence, SRAM ready handshake, CPU stall and hit/miss counters.
module cache_nway_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 7,
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              sram_rd,
    output logic              sram_wr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              error
);

    localparam int TAG_W     = tag_w(ADDR_W, SET_BITS);
    localparam int WAY_IDX_W = way_idx_w(WAYS);
    localparam int NSETS     = nsets(SET_BITS);

    cache_state_e state, state_next;
    logic [SET_BITS-1:0]  init_cnt;
    logic [WAY_IDX_W-1:0] victim_q;

    logic [WAYS-1:0]   valid_q [NSETS];
    logic [WAYS-1:0]   mru_q   [NSETS];
    logic [TAG_W-1:0]  tag_q   [NSETS][WAYS];
    logic [DATA_W-1:0] data_q  [NSETS][WAYS];

    logic [SET_BITS-1:0]  idx;
    logic [TAG_W-1:0]     tag;
    logic [WAYS-1:0]      hit_vec;
    logic                 hit_any;
    logic [WAY_IDX_W-1:0] hit_way;
    logic [DATA_W-1:0]    hit_data;
    logic [WAY_IDX_W-1:0] access_way;
    logic [WAY_IDX_W-1:0] sel_victim;
    logic [WAYS-1:0]      mru_next;
    logic                 rd_hit, rd_miss, rd_fill, wr_update;

    assign idx = cpu_addr[SET_BITS-1:0];
    assign tag = cpu_addr[ADDR_W-1:SET_BITS];

    always_comb begin
        hit_vec  = '0;
        hit_any  = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int i = 0; i < WAYS; i++) begin
            hit_vec[i] = valid_q[idx][i] && (tag_q[idx][i] == tag);
            if (hit_vec[i]) begin
                hit_any  = 1'b1;
                hit_way  = WAY_IDX_W'(i);
                hit_data = data_q[idx][i];
            end
        end
    end

    assign rd_hit    = (state == IDLE) && cpu_rd && !cpu_wr && hit_any;
    assign rd_miss   = (state == IDLE) && cpu_rd && !cpu_wr && !hit_any;
    assign rd_fill   = (state == RD_MISS) && sram_ready;
    assign wr_update = (state == WR_THRU) && sram_ready && hit_any;
    // During a fill the touched way is the latched victim, otherwise the hit way.
    assign access_way = (state == RD_MISS) ? victim_q : hit_way;

    cache_plru_sel #(
        .WAYS      (WAYS),
        .WAY_IDX_W (WAY_IDX_W)
    ) u_plru (
        .valid      (valid_q[idx]),
        .mru        (mru_q[idx]),
        .access_way (access_way),
        .victim     (sel_victim),
        .mru_next   (mru_next)
    );

    always_comb begin
        state_next = state;
        cpu_stall  = 1'b1;
        cpu_rdata  = '0;
        sram_rd    = 1'b0;
        sram_wr    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        error      = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == '1) state_next = IDLE;
            end
            IDLE: begin
                cpu_stall = 1'b0;
                if (cpu_rd && cpu_wr) begin
                    error = 1'b1;
                end else if (cpu_rd) begin
                    if (hit_any) begin
                        cpu_rdata = hit_data;
                    end else begin
                        cpu_stall  = 1'b1;
                        state_next = RD_MISS;
                    end
                end else if (cpu_wr) begin
                    cpu_stall  = 1'b1;
                    state_next = WR_THRU;
                end
            end
            RD_MISS: begin
                sram_rd   = 1'b1;
                sram_addr = cpu_addr;
                if (sram_ready) begin
                    cpu_rdata  = sram_rdata;
                    cpu_stall  = 1'b0;
                    state_next = IDLE;
                end
            end
            WR_THRU: begin
                sram_wr    = 1'b1;
                sram_addr  = cpu_addr;
                sram_wdata = cpu_wdata;
                if (sram_ready) begin
                    cpu_stall  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase
        // Reset aborts any access in flight, including its SRAM strobe.
        if (reset) begin
            cpu_stall = 1'b1;
            cpu_rdata = '0;
            sram_rd   = 1'b0;
            sram_wr   = 1'b0;
            error     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            victim_q <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (rd_hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
            if (rd_miss) begin
                victim_q <= sel_victim;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                valid_q[init_cnt] <= '0;
                mru_q[init_cnt]   <= '0;
            end
            if (rd_hit) mru_q[idx] <= mru_next;
            if (rd_fill) begin
                tag_q[idx][victim_q]   <= tag;
                data_q[idx][victim_q]  <= sram_rdata;
                valid_q[idx][victim_q] <= 1'b1;
                mru_q[idx]             <= mru_next;
            end
            if (wr_update) begin
                data_q[idx][hit_way] <= cpu_wdata;
                mru_q[idx]           <= mru_next;
            end
        end
    end

endmodule
